// File: rtl/return_stack.sv
// Return-address LIFO for the A09 sequencer: push on CALL, pop on RET, with sticky
// overflow/underflow flags that the control matrix uses to halt.
module return_stack #(
  parameter int DataWidth = 16,
  parameter int Depth     = 8,
  parameter int AddrWidth = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Clr,
  input  logic                 Push,
  input  logic                 Pop,
  input  logic [DataWidth-1:0] DIn,
  output logic [DataWidth-1:0] DOut,
  output logic [AddrWidth:0]   Count,
  output logic                 Empty,
  output logic                 Full,
  output logic                 Overflow,
  output logic                 Underflow,
  output logic                 Error
);

  localparam logic [AddrWidth:0] FullCount = (AddrWidth+1)'(Depth);

  logic [DataWidth-1:0] mem [Depth];
  logic [AddrWidth:0]   sp;
  logic [AddrWidth:0]   sp_next;
  logic [AddrWidth-1:0] top_idx;
  logic [AddrWidth-1:0] wr_idx;
  logic                 wr_en;
  logic                 set_ovf;
  logic                 set_unf;
  logic                 empty;
  logic                 full;

  assign empty   = (sp == '0);
  assign full    = (sp == FullCount);
  assign top_idx = AddrWidth'(sp - 1'b1);

  // Push+Pop together replaces the top entry; on an empty stack it degrades to a push.
  always_comb begin
    sp_next = sp;
    wr_en   = 1'b0;
    wr_idx  = sp[AddrWidth-1:0];
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case ({Push, Pop})
      2'b10: begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          wr_en   = 1'b1;
          sp_next = sp + 1'b1;
        end
      end
      2'b01: begin
        if (empty) set_unf = 1'b1;
        else       sp_next = sp - 1'b1;
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty) sp_next = sp + 1'b1;
        else       wr_idx  = top_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sp        <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (Clr) begin
      sp        <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      Overflow  <= Overflow | set_ovf;
      Underflow <= Underflow | set_unf;
    end
  end

  // Entry storage carries no reset; emptiness is tracked by sp and DOut is gated below.
  always_ff @(posedge Clk) begin
    if (wr_en && !Clr && Reset) mem[wr_idx] <= DIn;
  end

  assign DOut  = empty ? '0 : mem[top_idx];
  assign Count = sp;
  assign Empty = empty;
  assign Full  = full;
  assign Error = Overflow | Underflow;

endmodule
